// File: rtl/hilo_muldiv_unit.sv
// HI/LO register file with a 32-cycle iterative multiply (shift-add) and
// restoring divide; mthi/mtlo/mfhi/mflo share the same HI/LO pair.
//   state  | meaning
//   S_IDLE | HI/LO moves served, mult/div may issue
//   S_MUL  | one shift-add step per cycle
//   S_DIV  | one restoring shift-subtract step per cycle
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [2:0]       HiLotype,
    input  logic             is_div,
    input  logic             ifunsigned,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic [WIDTH-1:0] hilo_rdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [2:0] HL_MTHI   = 3'b101;
    localparam logic [2:0] HL_MTLO   = 3'b011;
    localparam logic [2:0] HL_MFHI   = 3'b100;
    localparam logic [2:0] HL_MFLO   = 3'b010;
    localparam logic [2:0] HL_MULDIV = 3'b111;
    localparam logic [2:0] HL_NONE   = 3'b000;

    localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [5:0]       r_cnt;
    logic [WIDTH-1:0] r_mag_b;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_signed;
    logic [WIDTH-1:0] r_rs_orig;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_low;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic               w_issue;
    logic [WIDTH-1:0]   w_mag_rs;
    logic [WIDTH-1:0]   w_mag_rt;
    logic [WIDTH:0]     w_add;
    logic [WIDTH-1:0]   w_mul_acc;
    logic [WIDTH-1:0]   w_mul_low;
    logic [WIDTH:0]     w_shift;
    logic               w_fits;
    logic [WIDTH-1:0]   w_div_acc;
    logic [WIDTH-1:0]   w_div_low;
    logic               w_neg;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_issue  = valid && (HiLotype == HL_MULDIV) && (r_state == S_IDLE);
    assign w_mag_rs = (!ifunsigned && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    assign w_mag_rt = (!ifunsigned && rt_data[WIDTH-1]) ? -rt_data : rt_data;

    // Multiply: r_low holds the multiplier and collects product low bits from the top.
    assign w_add     = {1'b0, r_acc} + (r_low[0] ? {1'b0, r_mag_b} : '0);
    assign w_mul_acc = w_add[WIDTH:1];
    assign w_mul_low = {w_add[0], r_low[WIDTH-1:1]};

    // Divide: r_acc is the partial remainder, r_low shifts dividend out and quotient in.
    assign w_shift   = {r_acc, r_low[WIDTH-1]};
    assign w_fits    = (w_shift >= {1'b0, r_mag_b});
    assign w_div_acc = w_fits ? (w_shift[WIDTH-1:0] - r_mag_b) : w_shift[WIDTH-1:0];
    assign w_div_low = {r_low[WIDTH-2:0], w_fits};

    assign w_neg      = r_signed && (r_sign_a ^ r_sign_b);
    assign w_prod     = {w_mul_acc, w_mul_low};
    assign w_prod_fix = w_neg ? -w_prod : w_prod;
    assign w_quo_fix  = w_neg ? -w_div_low : w_div_low;
    assign w_rem_fix  = (r_signed && r_sign_a) ? -w_div_acc : w_div_acc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_mag_b   <= '0;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_signed  <= 1'b0;
            r_rs_orig <= '0;
            r_acc     <= '0;
            r_low     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_issue) begin
                r_state   <= is_div ? S_DIV : S_MUL;
                r_cnt     <= '0;
                r_mag_b   <= w_mag_rt;
                r_sign_a  <= rs_data[WIDTH-1];
                r_sign_b  <= rt_data[WIDTH-1];
                r_signed  <= !ifunsigned;
                r_rs_orig <= rs_data;
                r_acc     <= '0;
                r_low     <= w_mag_rs;
            end else if (valid && (HiLotype == HL_MTHI)) begin
                r_hi <= rs_data;
            end else if (valid && (HiLotype == HL_MTLO)) begin
                r_lo <= rs_data;
            end
        end else begin
            r_acc <= (r_state == S_DIV) ? w_div_acc : w_mul_acc;
            r_low <= (r_state == S_DIV) ? w_div_low : w_mul_low;
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == LAST_STEP) begin
                r_state <= S_IDLE;
                if (r_state == S_MUL) begin
                    {r_hi, r_lo} <= w_prod_fix;
                end else if (r_mag_b == '0) begin
                    r_hi <= r_rs_orig;
                    r_lo <= '1;
                end else begin
                    r_hi <= w_rem_fix;
                    r_lo <= w_quo_fix;
                end
            end
        end
    end

    always_comb begin
        hilo_rdata = '0;
        if (reset) begin
            if (HiLotype == HL_MFHI) begin
                hilo_rdata = r_hi;
            end else if (HiLotype == HL_MFLO) begin
                hilo_rdata = r_lo;
            end
        end
    end

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign busy  = (r_state != S_IDLE);
    assign stall = reset && valid && (HiLotype != HL_NONE) && busy;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: randomized mult/div against an
// arithmetic reference model plus directed stall, abort and HI/LO move scenarios.
module tb_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [2:0]  HiLotype;
    logic        is_div;
    logic        ifunsigned;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] hilo_rdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .valid(valid), .HiLotype(HiLotype),
        .is_div(is_div), .ifunsigned(ifunsigned), .rs_data(rs_data),
        .rt_data(rt_data), .hilo_rdata(hilo_rdata), .hi(hi), .lo(lo),
        .busy(busy), .stall(stall)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model(input bit dv, input bit uns, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] mh,
                                  output logic [31:0] ml);
        longint sp;
        logic [63:0] up;
        if (!dv) begin
            if (uns) begin
                up = {32'b0, a} * {32'b0, b};
            end else begin
                sp = longint'($signed(a)) * longint'($signed(b));
                up = sp;
            end
            mh = up[63:32];
            ml = up[31:0];
        end else if (b == 32'd0) begin
            ml = '1;
            mh = a;
        end else if (uns) begin
            ml = a / b;
            mh = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            ml = 32'h8000_0000;
            mh = 32'd0;
        end else begin
            ml = $signed(a) / $signed(b);
            mh = $signed(a) % $signed(b);
        end
    endfunction

    task automatic idle_inputs();
        valid = 1'b0; HiLotype = 3'b000; is_div = 1'b0; ifunsigned = 1'b0;
        rs_data = '0; rt_data = '0;
    endtask

    task automatic issue(input bit dv, input bit uns, input logic [31:0] a, input logic [31:0] b);
        valid = 1'b1; HiLotype = 3'b111; is_div = dv; ifunsigned = uns;
        rs_data = a; rt_data = b;
        @(posedge clk); #1;
        valid = 1'b0; HiLotype = 3'b000;
    endtask

    task automatic run_op(input string name, input bit dv, input bit uns,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mh, ml;
        int n;
        model(dv, uns, a, b, mh, ml);
        issue(dv, uns, a, b);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected 32", name, n);
        end
        checks++;
        if (hi !== mh) begin
            errors++;
            $display("FAIL %s hi: a=%h b=%h got %h expected %h", name, a, b, hi, mh);
        end
        checks++;
        if (lo !== ml) begin
            errors++;
            $display("FAIL %s lo: a=%h b=%h got %h expected %h", name, a, b, lo, ml);
        end
        exp_hi = mh;
        exp_lo = ml;
    endtask

    task automatic test_reset();
        reset = 1'b0; valid = 1'b1; HiLotype = 3'b100; rs_data = $urandom; rt_data = $urandom;
        #1;
        checks++;
        if (stall !== 1'b0 || hilo_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: stall=%b rdata=%h expected 0 and 0", stall, hilo_rdata);
        end
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b hi=%h lo=%h expected 0", busy, hi, lo);
        end
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        exp_hi = '0; exp_lo = '0;
    endtask

    task automatic test_moves();
        logic [31:0] v;
        for (int i = 0; i < 8; i++) begin
            v = $urandom;
            valid = 1'b1; rs_data = v;
            if (i % 2 == 0) begin HiLotype = 3'b101; exp_hi = v; end
            else begin HiLotype = 3'b011; exp_lo = v; end
            @(posedge clk); #1;
            HiLotype = 3'b100; rs_data = $urandom; #1;
            checks++;
            if (hilo_rdata !== exp_hi || stall !== 1'b0) begin
                errors++;
                $display("FAIL mfhi: got %h stall=%b expected %h", hilo_rdata, stall, exp_hi);
            end
            HiLotype = 3'b010; #1;
            checks++;
            if (hilo_rdata !== exp_lo) begin
                errors++;
                $display("FAIL mflo: got %h expected %h", hilo_rdata, exp_lo);
            end
            HiLotype = 3'b000; #1;
            checks++;
            if (hilo_rdata !== 32'd0) begin
                errors++;
                $display("FAIL rdata_none: got %h expected 0", hilo_rdata);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_directed();
        run_op("mult_neg2x3", 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd3);
        run_op("multu_max", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_m7_2", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_by0", 1'b1, 1'b1, 32'd7, 32'd0);
        run_op("div_by0_signed", 1'b1, 1'b0, 32'h8000_0005, 32'd0);
        run_op("div_overflow", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_neg_neg", 1'b1, 1'b0, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
        run_op("mult_minint", 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        bit dv, uns;
        for (int i = 0; i < 30; i++) begin
            dv  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 31);
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            run_op("random", dv, uns, a, b);
        end
    endtask

    task automatic test_mfhi_stall();
        logic [31:0] a, b, mh, ml, old_hi;
        int n;
        bit bad;
        a = $urandom; b = $urandom_range(1, 1000);
        model(1'b1, 1'b0, a, b, mh, ml);
        old_hi = hi;
        issue(1'b1, 1'b0, a, b);
        @(posedge clk); #1;
        valid = 1'b1; HiLotype = 3'b100; #1;
        n = 0; bad = 0;
        while (busy && n < 100) begin
            if (stall !== 1'b1 || hi !== old_hi) bad = 1;
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad || n !== 31) begin
            errors++;
            $display("FAIL mfhi_stall_window: bad=%0d cycles=%0d expected bad=0 cycles=31", bad, n);
        end
        checks++;
        if (stall !== 1'b0 || hilo_rdata !== mh) begin
            errors++;
            $display("FAIL mfhi_after_busy: stall=%b rdata=%h expected 0 and %h", stall, hilo_rdata, mh);
        end
        idle_inputs();
        exp_hi = mh; exp_lo = ml;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, mh, ml, old_hi, old_lo;
        int n;
        bit bad;
        a = $urandom; b = $urandom;
        model(1'b0, 1'b0, a, b, mh, ml);
        old_hi = hi; old_lo = lo;
        issue(1'b0, 1'b0, a, b);
        n = 0; bad = 0;
        while (busy && n < 100) begin
            if (n == 4) begin
                valid = 1'b1; HiLotype = 3'b111; is_div = 1'b1; ifunsigned = 1'b1;
                rs_data = $urandom; rt_data = $urandom;
            end
            if (n == 10) begin HiLotype = 3'b101; rs_data = $urandom; end
            if (n == 14) begin HiLotype = 3'b111; is_div = 1'b0; end
            #1;
            if (n >= 4 && stall !== 1'b1) bad = 1;
            if (hi !== old_hi || lo !== old_lo) bad = 1;
            n++;
            @(posedge clk); #1;
        end
        idle_inputs();
        checks++;
        if (bad || n !== 32) begin
            errors++;
            $display("FAIL busy_issue_stall: bad=%0d cycles=%0d expected bad=0 cycles=32", bad, n);
        end
        checks++;
        if (hi !== mh || lo !== ml) begin
            errors++;
            $display("FAIL busy_issue_result: hi=%h lo=%h expected %h %h", hi, lo, mh, ml);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_issue_norestart: busy=%b expected 0", busy);
        end
        exp_hi = mh; exp_lo = ml;
    endtask

    task automatic test_abort();
        valid = 1'b1; HiLotype = 3'b101; rs_data = 32'hA5A5_1234;
        @(posedge clk); #1;
        HiLotype = 3'b011; rs_data = 32'h0F0F_5678;
        @(posedge clk); #1;
        idle_inputs();
        issue(1'b0, 1'b1, $urandom, $urandom);
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1;
        end
        reset = 1'b0; valid = 1'b1; HiLotype = 3'b100; #1;
        checks++;
        if (hilo_rdata !== 32'd0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_reset: rdata=%h stall=%b expected 0 and 0", hilo_rdata, stall);
        end
        @(posedge clk); #1;
        reset = 1'b1; idle_inputs();
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL abort_state: busy=%b hi=%h lo=%h expected 0", busy, hi, lo);
        end
        valid = 1'b1; HiLotype = 3'b101; rs_data = 32'h1234_5678;
        @(posedge clk); #1;
        HiLotype = 3'b100; rs_data = '0; #1;
        checks++;
        if (hilo_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL abort_mthi_mfhi: got %h expected 12345678", hilo_rdata);
        end
        idle_inputs();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
        end
        #1;
        checks++;
        if (hi !== 32'h1234_5678 || lo !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_late_write: hi=%h lo=%h busy=%b expected 12345678 0 0", hi, lo, busy);
        end
        exp_hi = 32'h1234_5678; exp_lo = '0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_moves();
        test_directed();
        test_random();
        test_mfhi_stall();
        test_back_to_back();
        test_abort();
        test_directed();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
